pixel_frame_sequencer: RTL

- Upstream stage of writepixel, the single-pixel NeoPixel serialiser.
- Holds a frame buffer of NUM_PIXELS 24-bit GRB words, written by a host port.
- On a frame request, feeds the words to writepixel one at a time using a start/busy handshake.
- After the last pixel, holds the line idle for a latch gap so the strip latches the frame.

---
 rtl/pixel_frame_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer
//   Frame buffer and sequencer that sits in front of writepixel, the
//   single-pixel NeoPixel serialiser. A host fills a buffer of NUM_PIXELS
//   GRB words. FRAME_GO streams the whole buffer to writepixel, one word per
//   start/busy handshake. After the last pixel the line is held idle for
//   LATCH_CYCLES clocks so that the strip latches the frame.
//
// Ports
//   CLK, RST_N           clock (rising edge), asynchronous active-low reset
//   WR_EN/ADDR/DATA      host write port; DATA = {G, R, B}
//   FRAME_GO             start one frame (only honoured when idle)
//   FRAME_BUSY           high from the accepted FRAME_GO to the end of the latch gap
//   FRAME_DONE           one-cycle pulse when the latch gap has elapsed
//   PIX_START            one-cycle request to writepixel
//   PIX_G/R/B            pixel bytes; held stable until the next pixel
//   PIX_BUSY             writepixel busy flag
module pixel_frame_sequencer #(
    parameter int unsigned NUM_PIXELS   = 8,
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned LATCH_CYCLES = 1200,
    parameter int unsigned LATCH_W      = 11
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [23:0]       WR_DATA,
    input  logic              FRAME_GO,
    output logic              FRAME_BUSY,
    output logic              FRAME_DONE,
    output logic              PIX_START,
    output logic [7:0]        PIX_G,
    output logic [7:0]        PIX_R,
    output logic [7:0]        PIX_B,
    input  logic              PIX_BUSY
);

    localparam int unsigned       Depth     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   NumPix    = (ADDR_W + 1)'(NUM_PIXELS);
    localparam logic [ADDR_W-1:0] LastIdx   = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [LATCH_W-1:0] LatchLast = LATCH_W'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StWaitAck,
        StWaitDone,
        StLatch,
        StDone
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  idx;
    logic [LATCH_W-1:0] latch_cnt;
    logic [23:0]        rd_word;

    // Storage is sized to the full address space so the address indexes it at
    // its natural width; entries at or beyond NUM_PIXELS are never written.
    logic [23:0] mem [Depth];

    logic wr_in_range;
    assign wr_in_range = ({1'b0, WR_ADDR} < NumPix);

    // Buffer: not reset. A same-cycle write and read of one address returns
    // the old word, so a write lands in this frame only if its index has not
    // been loaded yet.
    always_ff @(posedge CLK) begin
        if (WR_EN && wr_in_range) begin
            mem[WR_ADDR] <= WR_DATA;
        end
        if (state == StLoad) begin
            rd_word <= mem[idx];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= StIdle;
            idx        <= '0;
            latch_cnt  <= '0;
            FRAME_BUSY <= 1'b0;
            FRAME_DONE <= 1'b0;
            PIX_START  <= 1'b0;
            PIX_G      <= 8'h00;
            PIX_R      <= 8'h00;
            PIX_B      <= 8'h00;
        end else begin
            PIX_START  <= 1'b0;
            FRAME_DONE <= 1'b0;
            case (state)
                StIdle: begin
                    if (FRAME_GO) begin
                        idx        <= '0;
                        FRAME_BUSY <= 1'b1;
                        state      <= StLoad;
                    end
                end
                StLoad: begin
                    state <= StSend;
                end
                StSend: begin
                    PIX_G     <= rd_word[23:16];
                    PIX_R     <= rd_word[15:8];
                    PIX_B     <= rd_word[7:0];
                    PIX_START <= 1'b1;
                    state     <= StWaitAck;
                end
                StWaitAck: begin
                    if (PIX_BUSY) begin
                        state <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (!PIX_BUSY) begin
                        if (idx == LastIdx) begin
                            latch_cnt <= '0;
                            state     <= StLatch;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= StLoad;
                        end
                    end
                end
                StLatch: begin
                    if (latch_cnt == LatchLast) begin
                        state <= StDone;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                StDone: begin
                    // Outputs are registered: FRAME_DONE rises and FRAME_BUSY
                    // falls together in the following (idle) cycle, where a
                    // held FRAME_GO is already accepted again.
                    FRAME_DONE <= 1'b1;
                    FRAME_BUSY <= 1'b0;
                    state      <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
